sap_logic_primitives: RTL and testbench

Bundles the three storage/arithmetic primitives used across the SAP-U datapath:
- a positive-edge D flip-flop;
- a transparent-high D latch;
- a 4-bit carry-lookahead adder with DM74LS283 semantics.

The three functions are independent. They share only the clock and the asynchronous reset. Register, ALU and control slices instantiate this block rather than the discrete primitives.

---
 rtl/sap_common_pkg.sv | 6 +
 rtl/cla4_carry_unit.sv | 22 ++
 rtl/sap_logic_primitives.sv | 58 +++++
 tb/tb_sap_logic_primitives.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sap_common_pkg.sv
// Shared constants for the SAP-U primitive cells.
// Imported by every module in this slice.
package sap_common_pkg;
  localparam int   ADDER_WIDTH  = 4;
  localparam logic RESET_ACTIVE = 1'b0;
endpackage

// File: rtl/cla4_carry_unit.sv
// DM74LS283-style carry lookahead: every carry is a flat two-level
// sum of products of propagate/generate terms and the carry-in.
module cla4_carry_unit
  import sap_common_pkg::*;
(
  input  logic [ADDER_WIDTH:1]   p,
  input  logic [ADDER_WIDTH:1]   g,
  input  logic                   cin,
  output logic [ADDER_WIDTH+1:1] c
);

  always_comb begin
    c[1] = cin;
    c[2] = g[1] | (p[1] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & cin);
    c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
         | (p[4] & p[3] & p[2] & g[1]) | (p[4] & p[3] & p[2] & p[1] & cin);
  end

endmodule

// File: rtl/sap_logic_primitives.sv
// Flip-flop, transparent-high latch and 4-bit CLA adder shared by the
// SAP-U datapath. The three functions share only clk and reset_n.
module sap_logic_primitives
  import sap_common_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 dff_data,
  output logic                 dff_q,
  output logic                 dff_q_not,
  input  logic                 latch_enable,
  input  logic                 latch_data,
  output logic                 latch_q,
  output logic                 latch_q_not,
  input  logic [ADDER_WIDTH:1] add_a,
  input  logic [ADDER_WIDTH:1] add_b,
  input  logic                 add_cin,
  output logic [ADDER_WIDTH:1] add_sum,
  output logic                 add_cout
);

  logic                   dff_state;
  logic                   latch_state;
  logic [ADDER_WIDTH:1]   p;
  logic [ADDER_WIDTH:1]   g;
  logic [ADDER_WIDTH+1:1] c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (reset_n == RESET_ACTIVE) dff_state <= 1'b0;
    else                         dff_state <= dff_data;
  end

  // Reset dominates the gate; with the gate low the last value is held.
  always_latch begin
    if (reset_n == RESET_ACTIVE) latch_state <= 1'b0;
    else if (latch_enable)       latch_state <= latch_data;
  end

  // Complements come from the single stored bit so Q and Q_not never agree.
  assign dff_q       = dff_state;
  assign dff_q_not   = ~dff_state;
  assign latch_q     = latch_state;
  assign latch_q_not = ~latch_state;

  assign g = add_a & add_b;
  assign p = add_a ^ add_b;

  cla4_carry_unit u_carry (
    .p   (p),
    .g   (g),
    .cin (add_cin),
    .c   (c)
  );

  assign add_sum  = p ^ c[ADDER_WIDTH:1];
  assign add_cout = c[ADDER_WIDTH+1];

endmodule

// File: tb/tb_sap_logic_primitives.sv
// Directed self-checking bench for sap_logic_primitives.
module tb_sap_logic_primitives;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       dff_data = 1'b0;
  logic       dff_q, dff_q_not;
  logic       latch_enable = 1'b0;
  logic       latch_data = 1'b0;
  logic       latch_q, latch_q_not;
  logic [4:1] add_a = 4'd0;
  logic [4:1] add_b = 4'd0;
  logic       add_cin = 1'b0;
  logic [4:1] add_sum;
  logic       add_cout;

  int checks = 0;
  int failures = 0;

  logic [4:0] exp_q[$];

  // Directed adder vectors: a, b, cin, expected sum, expected cout
  logic [3:0] tv_a   [10] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd14, 4'd15, 4'd12, 4'd8, 4'd15, 4'd10};
  logic [3:0] tv_b   [10] = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd7,  4'd1,  4'd10, 4'd8, 4'd15, 4'd5};
  logic       tv_cin [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  1'b0,  1'b0,  1'b0, 1'b1,  1'b1};
  logic [3:0] tv_sum [10] = '{4'b0000, 4'b0011, 4'b1000, 4'b1001, 4'b0101,
                              4'b0000, 4'b0110, 4'b0000, 4'b1111, 4'b0000};
  logic       tv_cout[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  sap_logic_primitives dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dff_data     (dff_data),
    .dff_q        (dff_q),
    .dff_q_not    (dff_q_not),
    .latch_enable (latch_enable),
    .latch_data   (latch_data),
    .latch_q      (latch_q),
    .latch_q_not  (latch_q_not),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .add_cout     (add_cout)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n      = 1'b0;
    dff_data     = 1'b0;
    latch_enable = 1'b0;
    latch_data   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dff_q !== 1'b0 || dff_q_not !== 1'b1) begin
      failures++;
      $display("FAIL reset_dff: q=%b q_not=%b required q=0 q_not=1", dff_q, dff_q_not);
    end
    checks++;
    if (latch_q !== 1'b0 || latch_q_not !== 1'b1) begin
      failures++;
      $display("FAIL reset_latch: q=%b q_not=%b required q=0 q_not=1", latch_q, latch_q_not);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_dff_sequence();
    logic [3:0] seq = 4'b0011;  // applied MSB first: 0? no -- index explicitly below
    logic       prev = 1'b0;
    logic       vals[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    seq = 4'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dff_data = vals[i];
      #1;
      checks++;
      if (dff_q !== prev) begin
        failures++;
        $display("FAIL dff_hold[%0d]: q=%b required %b", i, dff_q, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (dff_q !== vals[i] || dff_q_not !== ~vals[i]) begin
        failures++;
        $display("FAIL dff_load[%0d]: q=%b q_not=%b required q=%b", i, dff_q, dff_q_not, vals[i]);
      end
      prev = vals[i];
    end
  endtask

  task automatic test_dff_async_reset();
    @(negedge clk);
    dff_data = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dff_q !== 1'b1) begin
      failures++;
      $display("FAIL dff_preload: q=%b required 1", dff_q);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (dff_q !== 1'b0 || dff_q_not !== 1'b1) begin
      failures++;
      $display("FAIL dff_async_reset: q=%b q_not=%b required q=0 q_not=1", dff_q, dff_q_not);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (dff_q !== 1'b0) begin
      failures++;
      $display("FAIL dff_after_release: q=%b required 0", dff_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dff_q !== 1'b1) begin
      failures++;
      $display("FAIL dff_first_load: q=%b required 1", dff_q);
    end
  endtask

  task automatic test_latch();
    logic en_v [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic d_v  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic q_v  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      latch_enable = en_v[i];
      latch_data   = d_v[i];
      #1;
      checks++;
      if (latch_q !== q_v[i] || latch_q_not !== ~q_v[i]) begin
        failures++;
        $display("FAIL latch_seq[%0d]: q=%b q_not=%b required q=%b", i, latch_q, latch_q_not, q_v[i]);
      end
      #3;
    end
    // Enable falls while data changes in the same timestep: old data kept.
    latch_enable = 1'b1;
    latch_data   = 1'b1;
    #1;
    latch_enable = 1'b0;
    latch_data   = 1'b0;
    #1;
    checks++;
    if (latch_q !== 1'b1) begin
      failures++;
      $display("FAIL latch_simul_fall: q=%b required 1", latch_q);
    end
    // Reset dominates an open gate.
    latch_enable = 1'b1;
    latch_data   = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (latch_q !== 1'b0 || latch_q_not !== 1'b1) begin
      failures++;
      $display("FAIL latch_reset_dominates: q=%b q_not=%b required q=0", latch_q, latch_q_not);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (latch_q !== 1'b1) begin
      failures++;
      $display("FAIL latch_after_release: q=%b required 1", latch_q);
    end
    latch_enable = 1'b0;
  endtask

  task automatic test_adder_directed();
    for (int i = 0; i < 10; i++) begin
      add_a   = tv_a[i];
      add_b   = tv_b[i];
      add_cin = tv_cin[i];
      #1;
      checks++;
      if (add_sum !== tv_sum[i] || add_cout !== tv_cout[i]) begin
        failures++;
        $display("FAIL adder_vec[%0d] %0d+%0d+%0d: sum=%b cout=%b required sum=%b cout=%b",
                 i, tv_a[i], tv_b[i], tv_cin[i], add_sum, add_cout, tv_sum[i], tv_cout[i]);
      end
    end
  endtask

  task automatic test_adder_exhaustive();
    logic [4:0] exp;
    int         errs = 0;
    for (int i = 0; i < 512; i++) begin
      add_a   = 4'(i[8:5]);
      add_b   = 4'(i[4:1]);
      add_cin = i[0];
      exp_q.push_back(5'(i[8:5]) + 5'(i[4:1]) + 5'(i[0]));
      if (i == 100) reset_n = 1'b0;
      if (i == 300) reset_n = 1'b1;
      #1;
      exp = exp_q.pop_front();
      checks++;
      if ({add_cout, add_sum} !== exp) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL adder_sweep a=%0d b=%0d cin=%0d: got %0d required %0d",
                   add_a, add_b, add_cin, {add_cout, add_sum}, exp);
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_dff_sequence();
    test_dff_async_reset();
    test_latch();
    test_adder_directed();
    test_adder_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
